// File: rtl/regfile_port_scheduler_if.sv
// Decode, writeback and register-file signals of the shared-port scheduler.
interface regfile_port_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
);
  localparam int unsigned NREG = 2 ** IDX_W;

  // decode read side
  logic              rd_req;
  logic [IDX_W-1:0]  rd_rs1;
  logic [IDX_W-1:0]  rd_rs2;
  logic [IDX_W-1:0]  rd_dest;
  logic              rd_dest_valid;
  logic              rd_stall;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_op1;
  logic [DATA_W-1:0] rd_op2;

  // writeback side
  logic              wb_req;
  logic [IDX_W-1:0]  wb_index;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;

  // scoreboard
  logic [NREG-1:0]   busy_vec;

  // register file port
  logic [IDX_W-1:0]  rf_index;
  logic [DATA_W-1:0] rf_value_in;
  logic              rf_read_en;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_value_out;

  modport slave (
    input  rd_req, rd_rs1, rd_rs2, rd_dest, rd_dest_valid,
    input  wb_req, wb_index, wb_data, rf_value_out,
    output rd_stall, rd_ack, rd_op1, rd_op2, wb_ack, busy_vec,
    output rf_index, rf_value_in, rf_read_en, rf_write_en
  );

  modport master (
    output rd_req, rd_rs1, rd_rs2, rd_dest, rd_dest_valid,
    output wb_req, wb_index, wb_data, rf_value_out,
    input  rd_stall, rd_ack, rd_op1, rd_op2, wb_ack, busy_vec,
    input  rf_index, rf_value_in, rf_read_en, rf_write_en
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Arbitrates the single register-file port between writeback and decode reads,
// tracks pending destinations in a busy scoreboard and stalls decode on hazards.
module regfile_port_scheduler #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned IDX_W        = 5,
  parameter int unsigned MAX_WB_BURST = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  regfile_port_scheduler_if.slave bus
);
  localparam int unsigned NREG     = 2 ** IDX_W;
  localparam int unsigned STREAK_W = $clog2(MAX_WB_BURST + 1);

  typedef enum logic [2:0] {IDLE, WR, RS1, RS2, CAP, ACK} state_t;

  state_t              state, next_state;
  logic [NREG-1:0]     busy;
  logic [STREAK_W-1:0] streak;
  logic [IDX_W-1:0]    rs2_q, dest_q, wb_idx_q;
  logic                dest_valid_q;
  logic                hazard, read_eligible, wr_grant, rd_grant;

  logic              rd_ack_q, wb_ack_q, rf_read_en_q, rf_write_en_q;
  logic [IDX_W-1:0]  rf_index_q;
  logic [DATA_W-1:0] rf_value_in_q, rd_op1_q, rd_op2_q;
  logic              rd_ack_d, wb_ack_d, rf_read_en_d, rf_write_en_d;
  logic [IDX_W-1:0]  rf_index_d;
  logic [DATA_W-1:0] rf_value_in_d;

  // Hazard detection and IDLE arbitration (writes win until the burst limit).
  always_comb begin
    hazard        = busy[bus.rd_rs1] | busy[bus.rd_rs2] |
                    (bus.rd_dest_valid & busy[bus.rd_dest]);
    read_eligible = bus.rd_req & ~hazard;
    wr_grant      = (state == IDLE) & bus.wb_req &
                    (~read_eligible | (streak < STREAK_W'(MAX_WB_BURST)));
    rd_grant      = (state == IDLE) & ~wr_grant & read_eligible;
  end

  assign bus.rd_stall = (state == IDLE) & bus.rd_req & hazard;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: a write is one cycle, a read walks RS1-RS2-CAP-ACK.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (wr_grant)      next_state = WR;
        else if (rd_grant) next_state = RS1;
      end
      WR:      next_state = IDLE;
      RS1:     next_state = RS2;
      RS2:     next_state = CAP;
      CAP:     next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the port outputs can be registered.
  always_comb begin
    rd_ack_d      = 1'b0;
    wb_ack_d      = 1'b0;
    rf_read_en_d  = 1'b0;
    rf_write_en_d = 1'b0;
    rf_index_d    = '0;
    rf_value_in_d = '0;
    unique case (next_state)
      WR: begin
        wb_ack_d = 1'b1;
        if (bus.wb_index != '0) begin
          rf_write_en_d = 1'b1;
          rf_index_d    = bus.wb_index;
          rf_value_in_d = bus.wb_data;
        end
      end
      RS1: begin
        rf_read_en_d = 1'b1;
        rf_index_d   = bus.rd_rs1;
      end
      RS2: begin
        rf_read_en_d = 1'b1;
        rf_index_d   = rs2_q;
      end
      ACK:     rd_ack_d = 1'b1;
      default: ;
    endcase
  end

  // Registered port and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack_q      <= 1'b0;
      wb_ack_q      <= 1'b0;
      rf_read_en_q  <= 1'b0;
      rf_write_en_q <= 1'b0;
      rf_index_q    <= '0;
      rf_value_in_q <= '0;
    end else begin
      rd_ack_q      <= rd_ack_d;
      wb_ack_q      <= wb_ack_d;
      rf_read_en_q  <= rf_read_en_d;
      rf_write_en_q <= rf_write_en_d;
      rf_index_q    <= rf_index_d;
      rf_value_in_q <= rf_value_in_d;
    end
  end

  // Request latches, operand capture, scoreboard and write-streak counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs2_q        <= '0;
      dest_q       <= '0;
      dest_valid_q <= 1'b0;
      wb_idx_q     <= '0;
      rd_op1_q     <= '0;
      rd_op2_q     <= '0;
      busy         <= '0;
      streak       <= '0;
    end else begin
      if (rd_grant) begin
        rs2_q        <= bus.rd_rs2;
        dest_q       <= bus.rd_dest;
        dest_valid_q <= bus.rd_dest_valid;
      end
      if (wr_grant) wb_idx_q <= bus.wb_index;
      if (state == RS2) rd_op1_q <= bus.rf_value_out;
      if (state == CAP) rd_op2_q <= bus.rf_value_out;
      if (state == WR) busy[wb_idx_q] <= 1'b0;
      else if ((state == CAP) && dest_valid_q && (dest_q != '0)) busy[dest_q] <= 1'b1;
      if (state == IDLE) begin
        if (rd_grant || !read_eligible) streak <= '0;
        else if (wr_grant && (streak < STREAK_W'(MAX_WB_BURST))) streak <= streak + 1'b1;
      end
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.wb_ack      = wb_ack_q;
  assign bus.rd_op1      = rd_op1_q;
  assign bus.rd_op2      = rd_op2_q;
  assign bus.busy_vec    = busy;
  assign bus.rf_index    = rf_index_q;
  assign bus.rf_value_in = rf_value_in_q;
  assign bus.rf_read_en  = rf_read_en_q;
  assign bus.rf_write_en = rf_write_en_q;
endmodule
